uart_tx_ctrl: RTL

Parametrised buffered UART transmitter, next generation of the single-byte TX path in the uart subsystem. Accepts bytes over a valid/ready write port into an internal FIFO and serialises them on `txd_o` with configurable data width, stop bits and optional parity. It derives bit timing from a clock-enable divider in the system clock domain instead of a generated baud clock. It sits between the core's memory-mapped UART register and the pad.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_tx_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states, parity modes and defaults for the uart TX path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int BAUD_DIV_DEFAULT = 434;

  // Zero-extended narrow data leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with registered full flag and level
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q;
  logic             full_q;
  logic             do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign do_push  = push_i && !full_q;
  assign do_pop   = pop_i && !empty_o;
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  assign data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o   = full_q;
  assign level_o  = level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= wr_ptr_d - rd_ptr_d;
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - buffered UART transmitter; parity via UART_TX_PARITY_EN
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          sys_rst,
  input  logic                          wr_valid_i,
  input  logic [DATA_BITS-1:0]          wr_data_i,
  output logic                          wr_ready_o,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                    parity_mode_i,
`endif
  output logic                          txd_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int CW = $clog2(BAUD_DIV);

  tx_state_e              state_q;
  logic [CW-1:0]          baud_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   txd_q, busy_q, done_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_en_q, par_val_q;
`endif

  logic                   fifo_full, fifo_empty, fifo_pop, wr_accept;
  logic [DATA_BITS-1:0]   fifo_data;
  logic                   bit_tick, last_stop;

  assign bit_tick  = (baud_cnt_q == CW'(BAUD_DIV - 1));
  assign last_stop = (state_q == STOP) && bit_tick && (bit_cnt_q == 3'(STOP_BITS - 1));
  assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || last_stop);
  assign wr_accept = wr_valid_i && !fifo_full;

  assign wr_ready_o = !fifo_full;
  assign txd_o      = txd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (sys_rst),
    .push_i  (wr_valid_i),
    .data_i  (wr_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  // txd_q follows the state one cycle late, so every line bit still spans BAUD_DIV cycles.
  always_ff @(posedge clk_i or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_val_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) baud_cnt_q <= bit_tick ? '0 : baud_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (fifo_pop) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= wr_accept;
          end
        end
        START: begin
          txd_q <= 1'b0;
          if (bit_tick) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          txd_q <= shift_q[0];
          if (bit_tick) begin
            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= par_en_q ? PARITY : STOP;
`else
              state_q   <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          txd_q <= par_val_q;
          if (bit_tick) begin
            state_q   <= STOP;
            bit_cnt_q <= '0;
          end
        end
`endif
        STOP: begin
          txd_q <= 1'b1;
          if (last_stop) begin
            done_q <= 1'b1;
            if (fifo_pop) begin
              state_q <= START;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= wr_accept;
            end
          end else if (bit_tick) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
      if (fifo_pop) begin
        shift_q    <= fifo_data;
        baud_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
        par_en_q   <= (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
        par_val_q  <= parity_bit(8'(fifo_data), parity_mode_i);
`endif
      end
    end
  end

endmodule
